// File: rtl/fft_pkg.sv
// Shared constants, reader state encoding and index bit-reversal for the
// FFT output reorder buffer.
package fft_pkg;

  localparam int FFT_BW    = 16;
  localparam int FFT_N     = 128;
  localparam int FFT_LOG2N = 7;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] i);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) r[b] = i[FFT_LOG2N-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bus: bit-reversed FFT samples in, natural-order samples out
// with valid/ready and frame markers.
interface fft_bitrev_reorder_if
  import fft_pkg::*;
#(
  parameter int BW    = FFT_BW,
  parameter int LOG2N = FFT_LOG2N
);
  logic             in_valid;
  logic             in_start;
  logic [BW-1:0]    In_Real;
  logic [BW-1:0]    In_Imag;
  logic             out_ready;
  logic             out_valid;
  logic             out_start;
  logic             out_last;
  logic [LOG2N-1:0] out_idx;
  logic [BW-1:0]    Out_Real;
  logic [BW-1:0]    Out_Imag;
  logic             overflow;

  modport slave (
    input  in_valid, in_start, In_Real, In_Imag, out_ready,
    output out_valid, out_start, out_last, out_idx, Out_Real, Out_Imag, overflow
  );

  modport master (
    output in_valid, in_start, In_Real, In_Imag, out_ready,
    input  out_valid, out_start, out_last, out_idx, Out_Real, Out_Imag, overflow
  );
endinterface

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Only the read-data register is reset; the array is not.
module fft_reorder_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read data only moves on an issued read, so it doubles as the held output data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Captures bit-reversed FFT frames into a ping-pong RAM and streams each frame
// out in natural order with valid/ready backpressure.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int BW    = FFT_BW,
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N
) (
  input logic                 clk,
  input logic                 reset_n,
  fft_bitrev_reorder_if.slave bus
);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N-1);

  // Writer
  logic [LOG2N-1:0] wcnt_q, wcnt_d, wr_idx;
  logic             wr_bank_q, wr_bank_d;
  logic             wr_en, wr_last;
  logic [1:0]       full_q, full_d, full_set, full_clr;
  logic             ovf_q, ovf_d;

  // Reader
  rd_state_e        state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rd_free, rd_issue, rd_last;

  // Output register
  logic             ov_q, ov_d;
  logic [LOG2N-1:0] idx_q, idx_d;
  logic             st_q, st_d, ls_q, ls_d;
  logic [2*BW-1:0]  rd_data;

  always_comb begin : writer_next
    wr_idx    = bus.in_start ? '0 : wcnt_q;
    wr_en     = bus.in_valid && !full_q[wr_bank_q];
    wr_last   = wr_en && (wr_idx == LAST_IDX);
    wcnt_d    = wcnt_q;
    wr_bank_d = wr_bank_q;
    full_set  = '0;
    ovf_d     = ovf_q;
    if (wr_en) wcnt_d = wr_last ? '0 : wr_idx + LOG2N'(1);
    if (wr_last) begin
      full_set[wr_bank_q] = 1'b1;
      wr_bank_d           = ~wr_bank_q;
    end
    if (bus.in_valid && full_q[wr_bank_q]) ovf_d = 1'b1;
  end

  // Writer and reader only ever touch different banks, so set/clear never collide.
  assign full_d = (full_q | full_set) & ~full_clr;

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : rd_next_state
    state_d = state_q;
    case (state_q)
      IDLE: if (full_q[rd_bank_q]) state_d = READ;
      READ: if (rd_issue && rd_last) state_d = full_q[~rd_bank_q] ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // IDLE may issue index 0 straight away so the first read lands one cycle
  // after the bank fills.
  always_comb begin : rd_outputs
    rd_free   = !ov_q || bus.out_ready;
    rd_issue  = rd_free && ((state_q == READ) || full_q[rd_bank_q]);
    rd_last   = (rcnt_q == LAST_IDX);
    rcnt_d    = rcnt_q;
    rd_bank_d = rd_bank_q;
    full_clr  = '0;
    if (rd_issue) begin
      rcnt_d = rd_last ? '0 : rcnt_q + LOG2N'(1);
      if (rd_last) begin
        full_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
      end
    end
  end

  always_comb begin : out_reg_next
    ov_d  = ov_q;
    idx_d = idx_q;
    st_d  = st_q;
    ls_d  = ls_q;
    if (rd_issue) begin
      ov_d  = 1'b1;
      idx_d = rcnt_q;
      st_d  = (rcnt_q == '0);
      ls_d  = rd_last;
    end else if (bus.out_ready) begin
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : regs
    if (!reset_n) begin
      wcnt_q    <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
      rd_bank_q <= 1'b0;
      rcnt_q    <= '0;
      ov_q      <= 1'b0;
      idx_q     <= '0;
      st_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      rd_bank_q <= rd_bank_d;
      rcnt_q    <= rcnt_d;
      ov_q      <= ov_d;
      idx_q     <= idx_d;
      st_q      <= st_d;
      ls_q      <= ls_d;
    end
  end

  fft_reorder_ram #(
    .AW (LOG2N + 1),
    .DW (2 * BW)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, bitrev(wr_idx)}),
    .wdata_i ({bus.In_Real, bus.In_Imag}),
    .re_i    (rd_issue),
    .raddr_i ({rd_bank_q, rcnt_q}),
    .rdata_o (rd_data)
  );

  assign bus.out_valid = ov_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_start = ov_q && st_q;
  assign bus.out_last  = ov_q && ls_q;
  assign bus.Out_Real  = rd_data[2*BW-1:BW];
  assign bus.Out_Imag  = rd_data[BW-1:0];
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the bit-reversal reorder buffer: frame ordering, latency,
// back-to-back streaming, backpressure, overflow, resync and async reset.
module tb_fft_bitrev_reorder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if bus ();
  fft_bitrev_reorder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int          idx;
    logic [15:0] re;
    logic [15:0] im;
    bit          st;
    bit          ls;
    int          cyc;
  } obs_t;

  obs_t q[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc++;

  // Accepted transfers, sampled mid-cycle while inputs are stable.
  always @(negedge clk)
    if (reset_n && bus.out_valid && bus.out_ready)
      q.push_back('{int'(bus.out_idx), bus.Out_Real, bus.Out_Imag,
                    bus.out_start, bus.out_last, cyc});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] brev(input logic [6:0] i);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) r[b] = i[6-b];
    return r;
  endfunction

  function automatic logic [15:0] sre(input int f, input int k);
    return 16'((f << 8) | k);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit-reversed-order sample k of frame f: Real = f<<8 | k, Imag = -Real.
  task automatic feed(input int f, input int k0, input int nsamp);
    for (int k = k0; k < k0 + nsamp; k++) begin
      bus.in_valid = 1'b1;
      bus.in_start = (k == 0);
      bus.In_Real  = sre(f, k);
      bus.In_Imag  = 16'(-int'(sre(f, k)));
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    for (int i = 0; i < budget && q.size() < n; i++) step();
  endtask

  task automatic check_frame(input string tag, input int base, input int f);
    int          bad;
    obs_t        o;
    logic [15:0] r;
    bad = 0;
    for (int n = 0; n < 128; n++) begin
      if (base + n >= q.size()) bad++;
      else begin
        o = q[base + n];
        r = sre(f, int'(brev(7'(n))));
        if (o.idx != n || o.re !== r || o.im !== 16'(-int'(r)) ||
            o.st != (n == 0) || o.ls != (n == 127)) bad++;
      end
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int gaps;
    int bad;

    bus.in_valid  = 1'b0;
    bus.in_start  = 1'b0;
    bus.In_Real   = '0;
    bus.In_Imag   = '0;
    bus.out_ready = 1'b0;
    step(3);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_data", {bus.Out_Real, bus.Out_Imag}, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_marks", {bus.out_start, bus.out_last}, 0);
    reset_n = 1'b1;
    step(2);

    // Single frame, latency and reorder
    bus.out_ready = 1'b1;
    q.delete();
    feed(0, 0, 128);
    chk("lat_t1_valid", bus.out_valid, 0);
    step();
    chk("lat_t2_valid", bus.out_valid, 1);
    chk("lat_t2_start", bus.out_start, 1);
    chk("lat_t2_idx", bus.out_idx, 0);
    wait_q(128, 300);
    chk("f0_count", q.size(), 128);
    if (q.size() >= 128) begin
      chk("f0_n0", q[0].re, 0);
      chk("f0_n1", q[1].re, 64);
      chk("f0_n1_im", q[1].im, 16'hFFC0);
      chk("f0_n2", q[2].re, 32);
      chk("f0_n3", q[3].re, 96);
      chk("f0_n127", q[127].re, 127);
    end
    check_frame("f0_frame", 0, 0);

    // Three frames back to back
    step(5);
    q.delete();
    feed(1, 0, 128);
    feed(2, 0, 128);
    feed(3, 0, 128);
    wait_q(384, 600);
    chk("b2b_count", q.size(), 384);
    check_frame("b2b_f1", 0, 1);
    check_frame("b2b_f2", 128, 2);
    check_frame("b2b_f3", 256, 3);
    gaps = 0;
    for (int i = 1; i < q.size(); i++) if (q[i].cyc != q[i-1].cyc + 1) gaps++;
    chk("b2b_gaps", gaps, 0);
    chk("b2b_ovf", bus.overflow, 0);

    // Backpressure at idx 5
    step(5);
    q.delete();
    feed(4, 0, 128);
    for (int i = 0; i < 50 && !(bus.out_valid && bus.out_idx == 5); i++) step();
    bus.out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!bus.out_valid || bus.out_idx != 5 || bus.Out_Real !== 16'h0450) bad++;
    end
    chk("bp_idx", bus.out_idx, 5);
    chk("bp_real", bus.Out_Real, 16'h0450);
    chk("bp_frozen", bad, 0);
    bus.out_ready = 1'b1;
    wait_q(128, 300);
    chk("bp_count", q.size(), 128);
    check_frame("bp_frame", 0, 4);

    // Overflow with the sink stalled
    step(5);
    q.delete();
    bus.out_ready = 1'b0;
    feed(5, 0, 128);
    feed(6, 0, 128);
    chk("ovf_before", bus.overflow, 0);
    feed(7, 0, 1);
    chk("ovf_set", bus.overflow, 1);
    feed(7, 1, 127);
    chk("ovf_noxfer", q.size(), 0);
    bus.out_ready = 1'b1;
    wait_q(256, 600);
    step(20);
    chk("ovf_count", q.size(), 256);
    check_frame("ovf_f5", 0, 5);
    check_frame("ovf_f6", 128, 6);
    chk("ovf_sticky", bus.overflow, 1);

    // Resync after a partial frame
    step(5);
    q.delete();
    feed(8, 0, 40);
    feed(9, 0, 128);
    wait_q(128, 400);
    step(20);
    chk("resync_count", q.size(), 128);
    check_frame("resync_f9", 0, 9);

    // Async reset mid-output
    step(5);
    q.delete();
    feed(10, 0, 128);
    for (int i = 0; i < 200 && !(bus.out_valid && bus.out_idx == 60); i++) step();
    chk("pre_rst_idx", bus.out_idx, 60);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_idx", bus.out_idx, 0);
    chk("mid_rst_ovf", bus.overflow, 0);
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("post_rst_quiet", bus.out_valid, 0);
    q.delete();
    feed(11, 0, 128);
    wait_q(128, 300);
    chk("post_rst_count", q.size(), 128);
    check_frame("post_rst_f11", 0, 11);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
